// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: tx_mux selection codes and the
// transmit-controller state encoding.
package uart_pkg;

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_DATA   = 2'b01;
  localparam logic [1:0] SEL_PARITY = 2'b10;
  localparam logic [1:0] SEL_STOP   = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte-input handshake into the UART transmit controller.
// The source drives the master side; uart_tx_ctrl uses the slave side.
interface uart_tx_ctrl_if #(
    parameter int DATA_BITS = 8
) ();

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 parity_en;
    logic                 parity_odd;

    modport master (
        output tx_data, tx_valid, parity_en, parity_odd,
        input  tx_ready
    );

    modport slave (
        input  tx_data, tx_valid, parity_en, parity_odd,
        output tx_ready
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and pulses
// bit_tick on the last cycle of each bit period.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic bit_tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
        end
    end

    assign bit_tick = en && (cnt == LAST_CNT);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer feeding tx_mux: start, LSB-first data, optional
// parity and stop bits. Define UART_TX_TWO_STOP_EN for two stop bits.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_ctrl_if.slave  tx_if,
    output logic [1:0]     selection,
    output logic           start_bit,
    output logic           data_bit,
    output logic           parity_bit,
    output logic           stop_bit,
    output logic           busy,
    output logic           tx_done,
    output tx_state_e      fsm_state
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    tx_state_e            state;
    logic [DATA_BITS-1:0] shift_reg;
    logic [IDX_W-1:0]     bit_idx;
    logic                 par_en_q;
    logic                 bit_tick;
    logic                 accept;
    logic                 frame_end;

    // Handshake: a byte transfers on a rising edge where tx_valid and
    // tx_ready are both high; tx_ready is high only while idle.
    assign tx_if.tx_ready = !busy;
    assign accept         = tx_if.tx_valid && tx_if.tx_ready;

    assign start_bit = 1'b0;
    assign stop_bit  = 1'b1;
    assign data_bit  = shift_reg[0];
    assign fsm_state = state;

`ifdef UART_TX_TWO_STOP_EN
    logic stop_second;
    assign frame_end = stop_second;
`else
    assign frame_end = 1'b1;
`endif

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (busy),
        .clr     (!busy),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            selection  <= SEL_STOP;
            shift_reg  <= '0;
            bit_idx    <= '0;
            parity_bit <= 1'b0;
            par_en_q   <= 1'b0;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop_second <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg  <= tx_if.tx_data;
                        parity_bit <= (^tx_if.tx_data) ^ tx_if.parity_odd;
                        par_en_q   <= tx_if.parity_en;
                        bit_idx    <= '0;
                        busy       <= 1'b1;
                        state      <= START;
                        selection  <= SEL_START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        state     <= DATA;
                        selection <= SEL_DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shift_reg <= shift_reg >> 1;
                        bit_idx   <= bit_idx + 1'b1;
                        if (bit_idx == LAST_IDX) begin
                            state     <= par_en_q ? PARITY : STOP;
                            selection <= par_en_q ? SEL_PARITY : SEL_STOP;
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        state     <= STOP;
                        selection <= SEL_STOP;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        // The done pulse coincides with tx_ready rising again.
                        if (frame_end) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            tx_done <= 1'b1;
                        end
`ifdef UART_TX_TWO_STOP_EN
                        stop_second <= !stop_second;
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    selection <= SEL_STOP;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl with CLKS_PER_BIT=4, DATA_BITS=8,
// composing the tx_mux line from the selection and bit-level outputs.
module tb_uart_tx_ctrl;
  import uart_pkg::*;

  localparam int CPB = 4;
`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_N = 2;
`else
  localparam int STOP_N = 1;
`endif

  logic clk;
  logic rst_n;
  logic [1:0] selection;
  logic start_bit, data_bit, parity_bit, stop_bit, busy, tx_done;
  tx_state_e fsm_state;
  logic line;

  uart_tx_ctrl_if #(.DATA_BITS(8)) tx_if ();

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tx_if(tx_if),
    .selection(selection),
    .start_bit(start_bit),
    .data_bit(data_bit),
    .parity_bit(parity_bit),
    .stop_bit(stop_bit),
    .busy(busy),
    .tx_done(tx_done),
    .fsm_state(fsm_state)
  );

  // tx_mux model
  assign line = (selection == 2'b00) ? start_bit :
                (selection == 2'b01) ? data_bit :
                (selection == 2'b10) ? parity_bit : stop_bit;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int frames = 0;
  int aborted = 0;
  int done_cnt = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: one entry per clock {selection, line, busy, tx_done}
  logic [4:0] exp_q[$];
  localparam logic [4:0] IDLE_ENT = {2'b11, 1'b1, 1'b0, 1'b0};

  function automatic void push_bit(input logic [1:0] s, input logic lvl, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({s, lvl, 1'b1, 1'b0});
  endfunction

  function automatic void build_frame(input logic [7:0] d, input logic pe, input logic po);
    push_bit(2'b00, 1'b0, CPB);
    for (int i = 0; i < 8; i++) push_bit(2'b01, d[i], CPB);
    if (pe) push_bit(2'b10, logic'($countones(d) % 2) ^ po, CPB);
    push_bit(2'b11, 1'b1, STOP_N * CPB);
    exp_q.push_back({2'b11, 1'b1, 1'b0, 1'b1});
  endfunction

  // model: a byte is taken whenever nothing is left to send
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (exp_q.size() > 0) aborted++;
      exp_q.delete();
    end else if (tx_if.tx_valid && exp_q.size() == 0) begin
      build_frame(tx_if.tx_data, tx_if.parity_en, tx_if.parity_odd);
      frames++;
    end
  end

  // compare process
  always @(negedge clk) begin
    logic [4:0] e;
    if (checking) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_ENT;
      check("cycle", {selection, line, busy, tx_if.tx_ready, tx_done},
            {e[4:3], e[2], e[1], !e[1], e[0]});
      if (tx_done) done_cnt++;
    end
  end

  // driver tasks
  task automatic drive_accept(input logic [7:0] d, input logic pe, input logic po);
    @(negedge clk);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data = d;
    tx_if.parity_en = pe;
    tx_if.parity_odd = po;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
  endtask

  // Starts at the first negedge after the accept edge; samples mid-bit.
  task automatic collect(output logic [11:0] bits, output int nbits,
                         output int done_at, output logic saw_par);
    int j;
    bits = '0; nbits = 0; done_at = -1; saw_par = 1'b0; j = 0;
    while (done_at < 0 && j < 400) begin
      if (selection == 2'b10) saw_par = 1'b1;
      if (tx_done) done_at = j;
      else if (j % CPB == 2) begin
        bits = {bits[10:0], line};
        nbits++;
      end
      j++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [11:0] bits;
    int nbits, done_at, d1, s2, first_done, ndone;
    logic saw_par;

    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    logic [11:0] bits;
    int nbits, done_at, d1, s2, first_done, ndone, j;
    logic saw_par;

    rst_n = 1'b0;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data = '0;
    tx_if.parity_en = 1'b0;
    tx_if.parity_odd = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_selection", selection, 2'b11);
    check("rst_bits", {start_bit, data_bit, parity_bit, stop_bit}, 4'b0001);
    check("rst_ready_busy_done", {tx_if.tx_ready, busy, tx_done}, 3'b100);
    check("rst_state", fsm_state, IDLE);
    rst_n = 1'b1;
    @(negedge clk);
    checking = 1'b1;
    check("idle_line", line, 1'b1);

    // 0xA5 even parity
    drive_accept(8'hA5, 1'b1, 1'b0);
    collect(bits, nbits, done_at, saw_par);
`ifdef UART_TX_TWO_STOP_EN
    check("a5_even_bits", bits, 12'b010100101011);
    check("a5_even_done", done_at, 48);
`else
    check("a5_even_bits", bits, 12'b000001010010101 & 12'hFFF);
    check("a5_even_done", done_at, 44);
`endif
    check("a5_even_saw_par", saw_par, 1'b1);

    // 0xA5 odd parity
    drive_accept(8'hA5, 1'b1, 1'b1);
    collect(bits, nbits, done_at, saw_par);
`ifdef UART_TX_TWO_STOP_EN
    check("a5_odd_bits", bits, 12'b010100101111);
    check("a5_odd_done", done_at, 48);
`else
    check("a5_odd_bits", bits, 12'b001010010111);
    check("a5_odd_done", done_at, 44);
`endif

    // 0x00 without parity
    drive_accept(8'h00, 1'b0, 1'b0);
    collect(bits, nbits, done_at, saw_par);
`ifdef UART_TX_TWO_STOP_EN
    check("zero_bits", bits, 12'b000000000011);
    check("zero_nbits", nbits, 11);
    check("zero_done", done_at, 44);
`else
    check("zero_bits", bits, 12'b000000000001);
    check("zero_nbits", nbits, 10);
    check("zero_done", done_at, 40);
`endif
    check("zero_no_par", saw_par, 1'b0);

    // back-to-back: tx_valid held across 0x55 then 0xFF
    @(negedge clk);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data = 8'h55;
    tx_if.parity_en = 1'b0;
    tx_if.parity_odd = 1'b0;
    @(negedge clk);
    tx_if.tx_data = 8'hFF;
    d1 = -1; s2 = -1; j = 0;
    while (s2 < 0 && j < 400) begin
      if (tx_done && d1 < 0) d1 = j;
      if (d1 >= 0 && j > d1 && selection == 2'b00) begin
        s2 = j;
        tx_if.tx_valid = 1'b0;
      end else begin
        j++;
        @(negedge clk);
      end
    end
    tx_if.tx_valid = 1'b0;
    check("b2b_done1", d1, 40 + 4 * (STOP_N - 1));
    check("b2b_start2", s2, 41 + 4 * (STOP_N - 1));
    collect(bits, nbits, done_at, saw_par);
`ifdef UART_TX_TWO_STOP_EN
    check("b2b_ff_bits", bits, 12'b001111111111);
`else
    check("b2b_ff_bits", bits, 12'b000111111111);
`endif
    check("b2b_ff_done", done_at, 40 + 4 * (STOP_N - 1));

    // tx_valid pulse with 0x3C mid-frame must be ignored
    drive_accept(8'hA5, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data = 8'h3C;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    ndone = 0; first_done = -1;
    for (int k = 11; k < 130; k++) begin
      if (tx_done) begin
        ndone++;
        if (first_done < 0) first_done = k;
      end
      @(negedge clk);
    end
    check("ignore_done_count", ndone, 1);
    check("ignore_done_at", first_done, 40 + 4 * (STOP_N - 1));

    // reset during DATA bit 3, then a clean 0x81 frame
    drive_accept(8'hC3, 1'b1, 1'b0);
    repeat (17) @(negedge clk);
    check("pre_rst_sel", selection, 2'b01);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_sel", selection, 2'b11);
    check("async_rst_busy_ready", {busy, tx_if.tx_ready, tx_done, line}, 4'b0101);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    drive_accept(8'h81, 1'b1, 1'b0);
    collect(bits, nbits, done_at, saw_par);
`ifdef UART_TX_TWO_STOP_EN
    check("x81_bits", bits, 12'b010000001011);
    check("x81_done", done_at, 48);
`else
    check("x81_bits", bits, 12'b001000000101);
    check("x81_done", done_at, 44);
`endif

    repeat (5) @(negedge clk);
    check("model_drained", exp_q.size(), 0);
    check("done_pulses", done_cnt, frames - aborted);
    check("aborted_frames", aborted, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Control and sequencing stage directly upstream of tx_mux in the UART transmitter.
- Accepts a parallel byte through a valid/ready handshake and generates the baud-rate timing.
- Drives tx_mux's selection code plus the start, data, parity and stop bit levels, so that tx_mux's data_out forms a complete RS-232 frame, LSB first.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200); must be >= 2.
- DATA_BITS, 8, payload bits per frame; legal range 5..8.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tx_data  input  DATA_BITS  byte to transmit; sampled on accept.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  block can accept a byte.
- parity_en  input  1  include parity bit; sampled on accept.
- parity_odd  input  1  1 = odd parity, 0 = even; sampled on accept.
- selection  output  2  to tx_mux: 00 start, 01 data, 10 parity, 11 stop/idle.
- start_bit  output  1  to tx_mux; constant 0.
- data_bit  output  1  to tx_mux; current payload bit.
- parity_bit  output  1  to tx_mux; computed parity.
- stop_bit  output  1  to tx_mux; constant 1.
- busy  output  1  frame in progress.
- tx_done  output  1  one-cycle pulse at end of the frame.

Behaviour:
- Reset values:
  - selection=11, stop_bit=1, start_bit=0, data_bit=0, parity_bit=0.
  - tx_ready=1, busy=0, tx_done=0.
  - State IDLE, baud counter=0, bit index=0.
  - The line therefore idles high.
- Accept condition: tx_valid & tx_ready on a rising edge.
  - tx_ready=1 only in IDLE. tx_valid while busy is ignored; no queuing.
  - On accept, latch tx_data into the shift register, and latch parity_en and parity_odd.
  - parity_bit = (^tx_data) ^ parity_odd, registered at accept.
- States and transitions:
  - IDLE: selection=11. On accept -> START.
  - START: selection=00. After CLKS_PER_BIT cycles -> DATA.
  - DATA: selection=01, data_bit = shift_reg[0]. Every CLKS_PER_BIT cycles, shift right and increment bit index. After DATA_BITS periods -> PARITY if parity_en, else STOP.
  - PARITY: selection=10 for CLKS_PER_BIT cycles -> STOP.
  - STOP: selection=11 for CLKS_PER_BIT cycles. Then -> IDLE with tx_done=1 for exactly one cycle.
- Latency and timing:
  - Accept at edge k: selection=00 from cycle k+1.
  - Every bit lasts exactly CLKS_PER_BIT cycles.
  - Frame length = (1+DATA_BITS+parity_en+1)*CLKS_PER_BIT cycles.
  - busy=1 from cycle k+1 until the last STOP cycle; tx_ready is its inverse.
  - Back-to-back frames: tx_ready returns high in the same cycle tx_done pulses. Accepting in that cycle starts START on the next cycle, so the minimum inter-frame gap is 1 clock.
- Baud counter: width clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary, and is held at 0 in IDLE.
- Reset mid-frame: outputs return to reset values immediately (asynchronously). The partial frame is abandoned and no tx_done is issued.
- Payloads narrower than 8 bits: only DATA_BITS bits are sent; the upper tx_data bits are ignored for both data and parity.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined: STOP lasts 2*CLKS_PER_BIT cycles; tx_done and the return to IDLE move to the end of the second stop period.
- Undefined: one stop bit, as above.

Decomposition:
- Shared package uart_pkg holds:
  - the selection codes SEL_START=2'b00, SEL_DATA=2'b01, SEL_PARITY=2'b10, SEL_STOP=2'b11 (shared with tx_mux);
  - the state encoding IDLE, START, DATA, PARITY, STOP.
- One natural sub-module, uart_baud_gen: the bit-period counter, with enable/clear inputs and a bit_tick output. The FSM, shift register and parity logic stay in uart_tx_ctrl.

Test Plan:
- CLKS_PER_BIT=4, tx_data=0xA5, parity_en=1, parity_odd=0, composed with tx_mux:
  - data_out = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then parity 0, then stop 1.
  - tx_done pulses at cycle 44 after accept.
- Same byte with parity_odd=1 -> parity period shows 1. tx_data=0x00 with parity_en=0 -> 40-cycle frame with no selection=10 period.
- Hold tx_valid high over two frames of 0x55 and 0xFF -> second START begins 1 cycle after tx_done; tx_ready is low for the whole of each frame.
- Pulse tx_valid with 0x3C mid-frame -> ignored; the frame in flight is unchanged and no extra frame is sent.
- Assert rst_n=0 during DATA bit 3 -> selection=11 and busy=0 immediately, tx_done never pulses; a new 0x81 frame afterwards is correct.
- UART_TX_TWO_STOP_EN defined, 0xA5 with parity -> stop high for 8 cycles; tx_done at cycle 48.
